snn_spike_stream_rx: RTL

// - AXI4-Stream sink for per-time-step neuron spike frames from the SNN core.

---
 rtl/snn_pkg.sv | 25 ++
 rtl/snn_neuron_rec.sv | 31 +++
 rtl/snn_spike_stream_rx.sv | 121 ++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared sizing, record type and FSM encoding for the SNN spike-stream receiver.
// Holds constants only; no timing or backpressure behaviour of its own.
package snn_pkg;

  localparam int N     = 4;
  localparam int T     = 1;
  localparam int TS    = 239;
  localparam int NN    = (N*T + 7) / 8;
  localparam int NU    = $clog2(TS + 1);
  localparam int CW    = NU;
  localparam int NA    = (N*T > 1) ? $clog2(N*T) : 1;
  localparam int NEVER = TS;

  typedef struct packed {
    logic [NU-1:0] first;
    logic [CW-1:0] cnt;
  } spike_rec_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

endpackage

// File: rtl/snn_neuron_rec.sv
// Per-neuron first-spike step and saturating spike count. Updates on the edge
// after upd and reads back combinationally; there is no backpressure.
module snn_neuron_rec #(
  parameter int NU    = 8,
  parameter int CW    = 8,
  parameter int NEVER = 239
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          upd,
  input  logic [NU-1:0] step,
  output logic [NU-1:0] first,
  output logic [CW-1:0] cnt
);

  localparam logic [NU-1:0] FIRST_NONE = NU'(NEVER);
  localparam logic [CW-1:0] CNT_MAX    = '1;

  // clr and upd never coincide: clr only happens outside a run
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      first <= FIRST_NONE;
      cnt   <= '0;
    end else if (upd) begin
      if (first == FIRST_NONE) first <= step;
      if (cnt != CNT_MAX)      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/snn_spike_stream_rx.sv
// AXI4-Stream sink recording first-spike step and spike count per neuron; read port has 1-cycle latency.
// Accepts one frame per clock while a run is active (tready=1); tready is 0 when idle or done.
module snn_spike_stream_rx #(
  parameter  int N  = snn_pkg::N,
  parameter  int T  = snn_pkg::T,
  parameter  int TS = snn_pkg::TS,
  parameter  int CW = $clog2(TS + 1),
  localparam int NT = N * T,
  localparam int NN = (NT + 7) / 8,
  localparam int NU = $clog2(TS + 1),
  localparam int NA = (NT > 1) ? $clog2(NT) : 1
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  input  logic [8*NN-1:0] s_axis_tdata,
  input  logic [NU-1:0] s_axis_tuser,
  input  logic          s_axis_tlast,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err_seq,
  input  logic [NA-1:0] rd_addr,
  output logic [NU-1:0] rd_first,
  output logic [CW-1:0] rd_count
);

  import snn_pkg::*;

  localparam logic [NU-1:0] LAST_TS = NU'(TS - 1);

  state_t        state_q, state_d;
  logic [NU-1:0] exp_ts_q;
  logic          err_q;
  logic          accept, last_step, run_end, clr, err_hit;

  logic [NU-1:0] first_a [NT];
  logic [CW-1:0] cnt_a   [NT];

  assign accept    = (state_q == S_RUN) && s_axis_tvalid;
  assign last_step = (exp_ts_q == LAST_TS);
  assign run_end   = accept && (s_axis_tlast || last_step);
  assign clr       = start && (state_q != S_RUN);
  // tlast must coincide exactly with the final step: early end or missing tlast both flag
  assign err_hit   = accept && ((s_axis_tuser != exp_ts_q) || (s_axis_tlast != last_step));

  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        s_axis_tready = 1'b1;
        busy          = 1'b1;
        if (run_end) state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn || clr)         exp_ts_q <= '0;
    else if (accept && !run_end) exp_ts_q <= exp_ts_q + 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn || clr) err_q <= 1'b0;
    else if (err_hit)    err_q <= 1'b1;
  end

  assign err_seq = err_q;

  for (genvar g = 0; g < NT; g++) begin : g_rec
    snn_neuron_rec #(
      .NU    (NU),
      .CW    (CW),
      .NEVER (TS)
    ) u_rec (
      .clk   (aclk),
      .rst_n (aresetn),
      .clr   (clr),
      .upd   (accept && s_axis_tdata[g]),
      .step  (exp_ts_q),
      .first (first_a[g]),
      .cnt   (cnt_a[g])
    );
  end

  if (8*NN > NT) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^s_axis_tdata[8*NN-1:NT];
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_first <= '0;
      rd_count <= '0;
    end else if (int'(rd_addr) < NT) begin
      rd_first <= first_a[rd_addr];
      rd_count <= cnt_a[rd_addr];
    end else begin
      rd_first <= NU'(TS);
      rd_count <= '0;
    end
  end

endmodule
